// File: rtl/data_memory_responder_if.sv
// Cache-controller <-> backing data memory handshake bundle.
// master = cache controller, slave = memory responder.
interface data_memory_responder_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
);
    logic [ADDR_W-1:0]   address;
    logic                read_data_memory;
    logic                write_data_memory;
    logic [DATA_W-1:0]   mem_wdata;
    logic                ready;
    logic [4*DATA_W-1:0] mem_rdata_block;
    logic                busy;

    modport master (
        output address, read_data_memory, write_data_memory, mem_wdata,
        input  ready, mem_rdata_block, busy
    );
    modport slave (
        input  address, read_data_memory, write_data_memory, mem_wdata,
        output ready, mem_rdata_block, busy
    );
endinterface

// File: rtl/data_memory_responder.sv
// Backing data memory: serves 4-word line reads and single-word writes after LATENCY cycles.
// Optional protocol checker enabled by defining DMEM_PROTO_CHECK_EN (adds sticky proto_err).
module data_memory_responder #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 4
) (
    input  logic clk,
    input  logic rst,
    data_memory_responder_if.slave bus
`ifdef DMEM_PROTO_CHECK_EN
    ,
    output logic proto_err
`endif
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP, RELEASE} state_t;

    state_t              state, state_n;
    logic [3:0]          cnt;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                op_rd_q;
    logic                ready_q;
    logic                busy_q;
    logic [4*DATA_W-1:0] rdata_q;
    logic [4*DATA_W-1:0] line;
    logic                req;
    logic                commit;

    // Array is not reset; it starts zeroed.
    logic [DATA_W-1:0] mem [2**ADDR_W] = '{default: '0};

    assign req    = bus.read_data_memory | bus.write_data_memory;
    assign commit = (state == BUSY) && (cnt == 4'd0);

    assign bus.ready           = ready_q;
    assign bus.busy            = busy_q;
    assign bus.mem_rdata_block = rdata_q;

    for (genvar k = 0; k < 4; k++) begin : g_line
        assign line[k*DATA_W +: DATA_W] = mem[{addr_q[ADDR_W-1:2], 2'(k)}];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (req) state_n = BUSY;
            BUSY:    if (cnt == 4'd0) state_n = RESP;
            RESP:    state_n = RELEASE;
            // Hold here until requests drop so a level request can't re-issue.
            RELEASE: if (!req) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            op_rd_q <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            ready_q <= (state_n == RESP);
            busy_q  <= (state_n == BUSY) || (state_n == RESP);
            if (state == IDLE && req) begin
                addr_q  <= bus.address;
                wdata_q <= bus.mem_wdata;
                op_rd_q <= bus.read_data_memory;
                cnt     <= 4'(LATENCY - 1);
            end else if (state == BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (commit && op_rd_q) rdata_q <= line;
        end
    end

    // Write lands on the same edge ready rises; reset in flight drops it.
    always_ff @(posedge clk) begin
        if (rst && commit && !op_rd_q) mem[addr_q] <= wdata_q;
    end

`ifdef DMEM_PROTO_CHECK_EN
    logic rd_d, wr_d;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            proto_err <= 1'b0;
            rd_d      <= 1'b0;
            wr_d      <= 1'b0;
        end else begin
            rd_d <= bus.read_data_memory;
            wr_d <= bus.write_data_memory;
            if ((state == IDLE && bus.read_data_memory && bus.write_data_memory) ||
                (state == BUSY && req && bus.address != addr_q) ||
                (state == RESP && ((bus.read_data_memory && !rd_d) ||
                                   (bus.write_data_memory && !wr_d))))
                proto_err <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_data_memory_responder.sv
// Directed + randomized bench for data_memory_responder against a word-array reference model.
module tb_data_memory_responder;
    localparam int LAT_A = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] ref_a [1024];

    always #5 clk = ~clk;

    data_memory_responder_if #(.DATA_W(32), .ADDR_W(10)) bus_a ();
    data_memory_responder_if #(.DATA_W(32), .ADDR_W(10)) bus_b ();

`ifdef DMEM_PROTO_CHECK_EN
    logic perr_a, perr_b;
`endif

    data_memory_responder #(.DATA_W(32), .ADDR_W(10), .LATENCY(LAT_A)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a)
`ifdef DMEM_PROTO_CHECK_EN
        , .proto_err(perr_a)
`endif
    );

    data_memory_responder #(.DATA_W(32), .ADDR_W(10), .LATENCY(1)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b)
`ifdef DMEM_PROTO_CHECK_EN
        , .proto_err(perr_b)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] line_a(input logic [9:0] a);
        logic [127:0] r;
        for (int k = 0; k < 4; k++) r[k*32 +: 32] = ref_a[{a[9:2], 2'(k)}];
        return r;
    endfunction

    // Called one step after acceptance; waits for ready and checks the response.
    task automatic finish_a(input logic rd, input logic [9:0] a, input logic [31:0] d);
        int n = 0;
        while (!bus_a.ready && n < 20) begin
            chk("busy_wait", 128'(bus_a.busy), 128'(1));
            tick();
            n++;
        end
        chk("latency", 128'(n), 128'(LAT_A));
        chk("busy_at_ready", 128'(bus_a.busy), 128'(1));
        if (rd) chk("rdata_line", bus_a.mem_rdata_block, line_a(a));
        else    ref_a[a] = d;
        tick();
        chk("ready_one_cycle", 128'(bus_a.ready), 128'(0));
        chk("busy_released", 128'(bus_a.busy), 128'(0));
        tick();
    endtask

    task automatic txn_a(input logic rd, input logic wr, input logic [9:0] a, input logic [31:0] d);
        bus_a.read_data_memory  = rd;
        bus_a.write_data_memory = wr;
        bus_a.address           = a;
        bus_a.mem_wdata         = d;
        tick();
        // Scramble inputs during BUSY: the latched copy must be used.
        bus_a.read_data_memory  = 1'b0;
        bus_a.write_data_memory = 1'b0;
        bus_a.address           = 10'($urandom);
        bus_a.mem_wdata         = $urandom;
        finish_a(rd, a, d);
    endtask

    initial begin
        logic [9:0]  a;
        logic [31:0] d;
        int          pulses;
        logic        rd;

        for (int i = 0; i < 1024; i++) ref_a[i] = '0;
        bus_a.read_data_memory = 0; bus_a.write_data_memory = 0; bus_a.address = 0; bus_a.mem_wdata = 0;
        bus_b.read_data_memory = 0; bus_b.write_data_memory = 0; bus_b.address = 0; bus_b.mem_wdata = 0;
        rst = 1'b1;
        #1 rst = 1'b0;
        tick(); tick();
        chk("rst_ready", 128'(bus_a.ready), 128'(0));
        chk("rst_busy", 128'(bus_a.busy), 128'(0));
        chk("rst_rdata", bus_a.mem_rdata_block, 128'(0));
        rst = 1'b1;
        tick();

        // Write then read of the same line.
        txn_a(1'b0, 1'b1, 10'h005, 32'hDEADBEEF);
        txn_a(1'b1, 1'b0, 10'h006, 32'h0);
        chk("read_word1", bus_a.mem_rdata_block, {32'h0, 32'h0, 32'hDEADBEEF, 32'h0});

        // Reset during BUSY aborts the write and clears outputs immediately.
        bus_a.write_data_memory = 1'b1; bus_a.address = 10'h040; bus_a.mem_wdata = 32'h12345678;
        tick();
        bus_a.write_data_memory = 1'b0;
        tick();
        chk("busy_before_rst", 128'(bus_a.busy), 128'(1));
        rst = 1'b0;
        #1;
        chk("midrst_ready", 128'(bus_a.ready), 128'(0));
        chk("midrst_busy", 128'(bus_a.busy), 128'(0));
        chk("midrst_rdata", bus_a.mem_rdata_block, 128'(0));
        tick();
        rst = 1'b1;
        tick();
        txn_a(1'b1, 1'b0, 10'h040, 32'h0);
        chk("aborted_write_absent", 128'(bus_a.mem_rdata_block[31:0]), 128'(0));

        // Level read held for 10 cycles yields exactly one response.
        a = 10'h005;
        bus_a.read_data_memory = 1'b1; bus_a.address = a;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus_a.ready) pulses++;
        end
        chk("held_one_pulse", 128'(pulses), 128'(1));
        chk("held_no_reaccept", 128'(bus_a.busy), 128'(0));
        chk("held_rdata", bus_a.mem_rdata_block, line_a(a));
        bus_a.read_data_memory = 1'b0;
        tick();
        chk("low_cycle_idle", 128'(bus_a.busy), 128'(0));
        bus_a.read_data_memory = 1'b1;
        tick();
        chk("reaccept_busy", 128'(bus_a.busy), 128'(1));
        bus_a.read_data_memory = 1'b0;
        finish_a(1'b1, a, 32'h0);

        // Randomized mix, half of it confined to a few lines so reads hit writes.
        for (int i = 0; i < 24; i++) begin
            a  = (i % 2 == 0) ? 10'($urandom_range(0, 31)) : 10'($urandom);
            d  = $urandom;
            rd = 1'($urandom);
            txn_a(rd, !rd, a, d);
        end

`ifdef DMEM_PROTO_CHECK_EN
        chk("proto_clean", 128'(perr_a), 128'(0));
`endif
        // Both requests high: read wins, write data dropped.
        txn_a(1'b0, 1'b1, 10'h3FC, 32'h11111111);
        txn_a(1'b1, 1'b1, 10'h3FC, 32'hCAFEF00D);
        txn_a(1'b1, 1'b0, 10'h3FE, 32'h0);
        chk("both_high_no_write", 128'(bus_a.mem_rdata_block[31:0]), 128'(32'h11111111));
`ifdef DMEM_PROTO_CHECK_EN
        chk("proto_both_high", 128'(perr_a), 128'(1));
`endif

        // LATENCY=1 instance: write top word, then read the top line.
        d = $urandom;
        bus_b.write_data_memory = 1'b1; bus_b.address = 10'h3FF; bus_b.mem_wdata = d;
        tick();
        bus_b.write_data_memory = 1'b0;
        tick();
        chk("l1_wr_ready", 128'(bus_b.ready), 128'(1));
        tick();
        chk("l1_wr_pulse", 128'(bus_b.ready), 128'(0));
        tick();
        bus_b.read_data_memory = 1'b1; bus_b.address = 10'h3FC;
        tick();
        bus_b.read_data_memory = 1'b0;
        tick();
        chk("l1_rd_ready", 128'(bus_b.ready), 128'(1));
        chk("l1_rd_line", bus_b.mem_rdata_block, {d, 32'h0, 32'h0, 32'h0});
        tick();
        chk("l1_rd_pulse", 128'(bus_b.ready), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
